// File: rtl/dla_noc_packetizer_pkg.sv
// Shared NoC flit types, sizes and helpers
// for the DLA-side packetizer and bridges.
package dla_noc_packetizer_pkg;

  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int DEST_ADDR_SIZE_L = 3;
  localparam int FLIT_DATA_SIZE   = 32;
  localparam int FLIT_LABEL_SIZE  = 2;
  localparam int FLIT_TOTAL_SIZE  =
    FLIT_LABEL_SIZE + FLIT_DATA_SIZE;
  localparam int PAYLOAD_SIZE     =
    DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + 2;

  typedef enum logic [FLIT_LABEL_SIZE-1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_GRNT = 2'd3
  } dla_pkt_state_t;

  // Head/headtail word: {label, 0.., pl, x, y, l}
  function automatic logic [FLIT_TOTAL_SIZE-1:0]
    pack_head_word(
      input flit_label_t                 label,
      input logic [DEST_ADDR_SIZE_X-1:0] x,
      input logic [DEST_ADDR_SIZE_Y-1:0] y,
      input logic [DEST_ADDR_SIZE_L-1:0] l,
      input logic [PAYLOAD_SIZE-1:0]     pl
    );
    localparam int LO = DEST_ADDR_SIZE_L;
    localparam int YO = LO + DEST_ADDR_SIZE_Y;
    localparam int XO = YO + DEST_ADDR_SIZE_X;
    logic [FLIT_DATA_SIZE-1:0] d;
    d = '0;
    d[0 +: DEST_ADDR_SIZE_L]  = l;
    d[LO +: DEST_ADDR_SIZE_Y] = y;
    d[YO +: DEST_ADDR_SIZE_X] = x;
    d[XO +: PAYLOAD_SIZE]     = pl;
    return {label, d};
  endfunction

endpackage

// File: rtl/dla_noc_packetizer.sv
// DLA-side NoC transmitter: builds HEAD/BODY/TAIL
// and HEADTAIL grant words into the injection FIFO.
module dla_noc_packetizer
  import dla_noc_packetizer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [DEST_ADDR_SIZE_X-1:0] req_dest_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] req_dest_y,
  input  logic [DEST_ADDR_SIZE_L-1:0] req_dest_l,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        dat_vld,
  output logic                        dat_rdy,
  input  logic [FLIT_DATA_SIZE-1:0]   dat,
  input  logic                        grnt_vld,
  output logic                        grnt_rdy,
  input  logic [DEST_ADDR_SIZE_X-1:0] grnt_dest_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] grnt_dest_y,
  input  logic [DEST_ADDR_SIZE_L-1:0] grnt_dest_l,
  input  logic [DEST_ADDR_SIZE_X-1:0] grnt_src_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] grnt_src_y,
  input  logic [1:0]                  grnt_dla,
  input  logic                        fifo_afull,
  input  logic                        fifo_full,
  output logic                        fifo_wen,
  output logic [FLIT_TOTAL_SIZE-1:0]  fifo_wdata,
  output logic                        busy,
  output logic                        err_len
);

  dla_pkt_state_t r_state;
  dla_pkt_state_t w_state_nxt;

  logic [DEST_ADDR_SIZE_X-1:0] r_dx;
  logic [DEST_ADDR_SIZE_Y-1:0] r_dy;
  logic [DEST_ADDR_SIZE_L-1:0] r_dl;
  logic [PAYLOAD_SIZE-1:0]     r_pl;
  logic [LEN_W-1:0]            r_len;
  logic [LEN_W-1:0]            r_rem;
  logic                        r_wen;
  logic [FLIT_TOTAL_SIZE-1:0]  r_wdata;
  logic                        r_err;

  logic                        w_space;
  logic                        w_wr;
  logic [FLIT_TOTAL_SIZE-1:0]  w_word;
  flit_label_t                 w_lbl;
  logic                        w_lat_req;
  logic                        w_lat_grnt;
  logic                        w_err;
  logic                        w_load;
  logic                        w_dec;

  assign w_space    = !fifo_afull && !fifo_full;
  assign busy       = (r_state != ST_IDLE);
  assign fifo_wen   = r_wen;
  assign fifo_wdata = r_wdata;
  assign err_len    = r_err;

  // Next state, handshakes and write decision
  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = 1'b0;
    grnt_rdy    = 1'b0;
    dat_rdy     = 1'b0;
    w_wr        = 1'b0;
    w_word      = r_wdata;
    w_lbl       = BODY;
    w_lat_req   = 1'b0;
    w_lat_grnt  = 1'b0;
    w_err       = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    if (!rst) begin
      unique case (r_state)
        ST_IDLE: begin
          grnt_rdy = grnt_vld;
          req_rdy  = !grnt_vld;
          if (grnt_vld) begin
            w_lat_grnt  = 1'b1;
            w_state_nxt = ST_GRNT;
          end else if (req_vld) begin
            if (req_len != '0) begin
              w_lat_req   = 1'b1;
              w_state_nxt = ST_HEAD;
            end else begin
              w_err = 1'b1;
            end
          end
        end
        ST_HEAD: begin
          if (w_space) begin
            w_wr   = 1'b1;
            w_word = pack_head_word(
              HEAD, r_dx, r_dy, r_dl, '0);
            w_load      = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          dat_rdy = w_space;
          if (dat_vld && w_space) begin
            w_wr  = 1'b1;
            w_dec = 1'b1;
            if (r_rem == LEN_W'(1)) begin
              w_lbl       = TAIL;
              w_state_nxt = ST_IDLE;
            end
            w_word = {w_lbl, dat};
          end
        end
        ST_GRNT: begin
          if (w_space) begin
            w_wr   = 1'b1;
            w_word = pack_head_word(
              HEADTAIL, r_dx, r_dy, r_dl, r_pl);
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered FIFO write stage and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wen <= w_wr;
      r_err <= w_err;
      if (w_wr) begin
        r_wdata <= w_word;
      end
    end
  end

  // Latched destination, payload and length counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx  <= '0;
      r_dy  <= '0;
      r_dl  <= '0;
      r_pl  <= '0;
      r_len <= '0;
      r_rem <= '0;
    end else begin
      if (w_lat_req) begin
        r_dx  <= req_dest_x;
        r_dy  <= req_dest_y;
        r_dl  <= req_dest_l;
        r_pl  <= '0;
        r_len <= req_len;
      end else if (w_lat_grnt) begin
        r_dx <= grnt_dest_x;
        r_dy <= grnt_dest_y;
        r_dl <= grnt_dest_l;
        r_pl <= {grnt_src_x, grnt_src_y, grnt_dla};
      end
      if (w_load) begin
        r_rem <= r_len;
      end else if (w_dec) begin
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

endmodule

// File: doc/dla_noc_packetizer.md
# dla_noc_packetizer

DLA-side transmitter that builds NoC packets and writes them, one FIFO word per flit, into the injection FIFO that the router bridge drains toward the router. It converts a packet request plus a data-word stream into HEAD, BODY and TAIL words. It converts a grant request into a single HEADTAIL word carrying the granted-source payload that the far-end bridge decodes into `dla2noc_granted_{x,y,dla}`.

## Interface
Parameters:
- `LEN_W`, default 8: width of the packet length field in data words.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req_vld`  in  1: data-packet request valid.
- `req_rdy`  out  1: data-packet request accepted.
- `req_dest_x / req_dest_y / req_dest_l`  in  `DEST_ADDR_SIZE_X / _Y / _L`: packet destination.
- `req_len`  in  `LEN_W`: number of data words, 1..2^LEN_W-1.
- `dat_vld`  in  1: data word valid.
- `dat_rdy`  out  1: data word accepted.
- `dat`  in  `FLIT_DATA_SIZE`: data word.
- `grnt_vld`  in  1: grant-packet request valid.
- `grnt_rdy`  out  1: grant-packet request accepted.
- `grnt_dest_x / grnt_dest_y / grnt_dest_l`  in  `DEST_ADDR_SIZE_X / _Y / _L`: grant destination.
- `grnt_src_x / grnt_src_y`  in  `DEST_ADDR_SIZE_X / _Y`: granted source coordinates.
- `grnt_dla`  in  2: granted DLA index.
- `fifo_afull`  in  1: injection FIFO almost full; asserted with at least 1 free entry remaining.
- `fifo_full`  in  1: injection FIFO full.
- `fifo_wen`  out  1: FIFO write enable, registered.
- `fifo_wdata`  out  `FLIT_TOTAL_SIZE`: FIFO write word, registered.
- `busy`  out  1: state is not IDLE.
- `err_len`  out  1: one-cycle pulse when a request with `req_len == 0` is dropped.

## Operation
- FIFO word format:
  - `[FLIT_TOTAL_SIZE-1:FLIT_DATA_SIZE]` holds the `flit_label_t` label.
  - The low `FLIT_DATA_SIZE` bits hold the data.
- Head and headtail data field layout:
  - `dest_l` at `[0 +: L]`.
  - `dest_y` at `[L +: Y]`.
  - `dest_x` at `[L+Y +: X]`.
  - Payload at `[L+Y+X +: X+Y+2]`, encoded as `{src_x, src_y, dla}` with `dla` in the LSBs.
  - All other bits are 0.
  - A HEAD word has payload 0.
- Body and tail words carry the raw `dat` value.
- `space` = `!fifo_afull && !fifo_full`, sampled in the current cycle.
- States and transitions:
  - **IDLE**
    - `grnt_rdy = grnt_vld`. Grant has priority.
    - `req_rdy = !grnt_vld`.
    - A grant handshake goes to GRNT.
    - A request handshake with `req_len != 0` latches dest and len and goes to HEAD.
    - A request handshake with `req_len == 0` pulses `err_len` and stays in IDLE.
  - **HEAD**: when `space`, write the HEAD word, load `remaining = len`, go to DATA.
  - **DATA**
    - `dat_rdy = space`.
    - On a data handshake, write the word with label TAIL if `remaining == 1`, otherwise BODY.
    - Each handshake decrements `remaining`.
    - After the TAIL write, go to IDLE.
  - **GRNT**: when `space`, write the HEADTAIL word, go to IDLE.
- Packets are never interleaved. A grant arriving mid-packet waits for IDLE.
- `dat_vld` outside DATA is ignored and `dat_rdy` is 0.
- While `rst` is high, `req_rdy`, `grnt_rdy` and `dat_rdy` are 0.

## Timing
- Reset values:
  - State = IDLE.
  - `fifo_wen` = 0, `fifo_wdata` = 0.
  - `remaining` = 0.
  - `busy` = 0, `err_len` = 0.
- Reset mid-packet abandons the packet with no TAIL. The next request starts clean.
- Write latency: a write decision in cycle t (the state condition plus `space`) gives `fifo_wen = 1` with the word in cycle t+1. When no write is decided, `fifo_wen = 0` and `fifo_wdata` holds its previous value.
- Request accepted at T, full space, data always valid:
  - HEAD written at T+2.
  - Data words at T+3 .. T+2+N.
  - Throughput is 1 flit per cycle.
- Grant accepted at T: HEADTAIL written at T+2.
- Next `req_rdy` or `grnt_rdy` is possible in the cycle after the TAIL or HEADTAIL write decision.
- FIFO backpressure: `afull` or `full` stalls the current state with no write and no data handshake. The `afull` margin absorbs the single in-flight registered write.

## Structure
- Use `flit_label_t` (HEAD/BODY/TAIL/HEADTAIL), `FLIT_*_SIZE` and `DEST_ADDR_SIZE_*` from the shared global include.
- Add to the shared package:
  - `dla_pkt_state_t`.
  - A pure function `pack_head_word(label, x, y, l, pl)` returning `FLIT_TOTAL_SIZE` bits, reused by future bridges.
- No sub-module: one FSM, a length counter and a registered output stage.

## Test plan
- `req_len=3`, `dest=(x2,y5,l1)`, data A,B,C, FIFO empty:
  - FIFO receives HEAD with `data[L+Y+X-1:0] = {2,5,1}`, then BODY A, BODY B, TAIL C.
  - Writes on 4 consecutive cycles starting T+2.
- `req_len=1`, data D: HEAD, then TAIL D. No BODY word.
- Grant with `src=(3,1)`, `dla=2`, `dest=(0,0,4)`: one HEADTAIL word with payload field = `{3,1,2'b10}`.
- `grnt_vld` and `req_vld` together in IDLE: grant written first, request accepted next cycle, HEAD follows the HEADTAIL.
- `fifo_afull` held high for 5 cycles mid-DATA: no writes and `dat_rdy=0` for those cycles; order and labels preserved after release.
- `rst` pulsed after the 2nd body word of `req_len=6`: `fifo_wen=0` the following cycle. A new request of len 2 then produces exactly HEAD, BODY, TAIL. Also `req_len=0` gives an `err_len` pulse and no writes.
